// File: rtl/uart_capture_monitor.sv
// UART pin capture: 2-flop sync, start/data/parity/stop deframing, and a FIFO of
// {perr, ferr, data} entries behind valid/ready. Dropped characters set a sticky overflow.
module uart_capture_monitor #(
  parameter int CLK_FREQ_HZ = 50000000,
  parameter int BAUD        = 115200,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        rx_i,
  output logic [DATA_BITS-1:0]        data_o,
  output logic                        perr_o,
  output logic                        ferr_o,
  output logic                        valid_o,
  input  logic                        ready_i,
  output logic [$clog2(FIFO_DEPTH):0] count_o,
  output logic                        overflow_o,
  output logic                        busy_o
);
  localparam int DIV = CLK_FREQ_HZ / BAUD;
  localparam int CW  = $clog2(DIV);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int EW  = DATA_BITS + 2;

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t               state;
  logic                 rx_meta, rxs, prev_hi;
  logic [1:0]           sync_ok;
  logic [CW-1:0]        cnt;
  logic [3:0]           bitcnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 perr, ferr, busy, push, par_exp;
  logic [EW-1:0]        push_ent;

  // prev_hi stays low until the synchroniser holds real line samples, so a line
  // that is already low when reset is released cannot look like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
      sync_ok <= '0;
      prev_hi <= 1'b0;
    end else begin
      rx_meta <= rx_i;
      rxs     <= rx_meta;
      sync_ok <= {sync_ok[0], 1'b1};
      prev_hi <= sync_ok[1] & rxs;
    end
  end

  assign par_exp = (^shreg) ^ (PARITY == 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      bitcnt   <= '0;
      shreg    <= '0;
      perr     <= 1'b0;
      ferr     <= 1'b0;
      busy     <= 1'b0;
      push     <= 1'b0;
      push_ent <= '0;
    end else begin
      push <= 1'b0;
      case (state)
        IDLE: begin
          if (prev_hi && !rxs) begin
            state <= START;
            busy  <= 1'b1;
            cnt   <= CW'(DIV/2 - 1);
            perr  <= 1'b0;
            ferr  <= 1'b0;
          end
        end
        START: begin
          if (cnt != '0) cnt <= cnt - CW'(1);
          else if (!rxs) begin
            state  <= DATA;
            cnt    <= CW'(DIV - 1);
            bitcnt <= '0;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        DATA: begin
          if (cnt != '0) cnt <= cnt - CW'(1);
          else begin
            cnt   <= CW'(DIV - 1);
            shreg <= {rxs, shreg[DATA_BITS-1:1]};
            if (bitcnt == 4'(DATA_BITS - 1)) begin
              bitcnt <= '0;
              state  <= (PARITY != 0) ? PAR : STOP;
            end else begin
              bitcnt <= bitcnt + 4'd1;
            end
          end
        end
        PAR: begin
          if (cnt != '0) cnt <= cnt - CW'(1);
          else begin
            cnt   <= CW'(DIV - 1);
            perr  <= (rxs != par_exp);
            state <= STOP;
          end
        end
        STOP: begin
          if (cnt != '0) cnt <= cnt - CW'(1);
          else if (bitcnt == 4'(STOP_BITS - 1)) begin
            push     <= 1'b1;
            push_ent <= {perr, ferr | ~rxs, shreg};
            state    <= IDLE;
            busy     <= 1'b0;
            bitcnt   <= '0;
          end else begin
            ferr   <= ferr | ~rxs;
            bitcnt <= bitcnt + 4'd1;
            cnt    <= CW'(DIV - 1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o = busy;

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW:0]   wptr, rptr;
  logic [EW-1:0] hold, head;
  logic          full, pop, wr, ovf;

  assign count_o = wptr - rptr;
  assign valid_o = (wptr != rptr);
  assign full    = (count_o == (AW+1)'(FIFO_DEPTH));
  assign pop     = valid_o && ready_i;
  assign wr      = push && (!full || pop);
  // With the FIFO empty the head shows the last entry popped.
  assign head    = valid_o ? mem[rptr[AW-1:0]] : hold;
  assign {perr_o, ferr_o, data_o} = head;
  assign overflow_o = ovf;

  always_ff @(posedge clk) begin
    if (wr) mem[wptr[AW-1:0]] <= push_ent;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      hold <= '0;
      ovf  <= 1'b0;
    end else begin
      if (wr) wptr <= wptr + (AW+1)'(1);
      if (pop) begin
        rptr <= rptr + (AW+1)'(1);
        hold <= head;
      end
      if (push && !wr) ovf <= 1'b1;
    end
  end
endmodule

// File: tb/tb_uart_capture_monitor.sv
// Bench: 8N1 and 7E2 capture instances at 10 clocks/bit, scoreboard queues popped by monitors.
module tb_uart_capture_monitor;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_a = 1'b1, rx_b = 1'b1, ready_a = 1'b1, ready_b = 1'b1;
  logic [7:0] data_a;
  logic [6:0] data_b;
  logic       perr_a, ferr_a, valid_a, overflow_a, busy_a;
  logic       perr_b, ferr_b, valid_b, overflow_b, busy_b;
  logic [2:0] count_a, count_b;
  logic       saw;
  int         total = 0;
  int         bad = 0;
  logic [10:0] exp_a[$];
  logic [10:0] exp_b[$];

  always #5 clk = ~clk;

  uart_capture_monitor #(.CLK_FREQ_HZ(1000000), .BAUD(100000), .DATA_BITS(8), .PARITY(0),
                         .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .rx_i(rx_a), .data_o(data_a), .perr_o(perr_a), .ferr_o(ferr_a),
    .valid_o(valid_a), .ready_i(ready_a), .count_o(count_a), .overflow_o(overflow_a), .busy_o(busy_a));

  uart_capture_monitor #(.CLK_FREQ_HZ(1000000), .BAUD(100000), .DATA_BITS(7), .PARITY(2),
                         .STOP_BITS(2), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .rx_i(rx_b), .data_o(data_b), .perr_o(perr_b), .ferr_o(ferr_b),
    .valid_o(valid_b), .ready_i(ready_b), .count_o(count_b), .overflow_o(overflow_b), .busy_o(busy_b));

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  function automatic logic [10:0] ent(input logic p, input logic f, input logic [8:0] d);
    return {p, f, d};
  endfunction

  always @(negedge clk) begin
    if (rst_n && valid_a && ready_a) begin
      if (exp_a.size() == 0) begin
        total++; bad++;
        $display("FAIL a_unexpected_pop: got %0h want none", {perr_a, ferr_a, 1'b0, data_a});
      end else begin
        check("a_entry", {perr_a, ferr_a, 1'b0, data_a}, exp_a.pop_front());
      end
    end
    if (rst_n && valid_b && ready_b) begin
      if (exp_b.size() == 0) begin
        total++; bad++;
        $display("FAIL b_unexpected_pop: got %0h want none", {perr_b, ferr_b, 2'b0, data_b});
      end else begin
        check("b_entry", {perr_b, ferr_b, 2'b0, data_b}, exp_b.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input bit which, input logic v, input int cycles);
    repeat (cycles) begin
      if (which) rx_b = v;
      else rx_a = v;
      tick();
    end
  endtask

  // par < 0 means no parity bit; stp[i] is the value of stop bit i.
  task automatic send(input bit which, input logic [8:0] d, input int nbits, input int par,
                      input logic [1:0] stp, input int nstop);
    drive(which, 1'b0, 10);
    for (int i = 0; i < nbits; i++) drive(which, d[i], 10);
    if (par >= 0) drive(which, par[0], 10);
    for (int i = 0; i < nstop; i++) drive(which, stp[i], 10);
    drive(which, 1'b1, 10);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    check("rst_outputs_a", {data_a, perr_a, ferr_a, valid_a, overflow_a, busy_a}, 0);
    check("rst_count_a", count_a, 0);
    check("rst_outputs_b", {data_b, perr_b, ferr_b, valid_b, overflow_b, busy_b, count_b}, 0);
    rst_n = 1'b1;
    repeat (5) tick();

    // 8N1 basic characters
    exp_a.push_back(ent(0, 0, 9'h055)); send(0, 9'h055, 8, -1, 2'b11, 1);
    exp_a.push_back(ent(0, 0, 9'h0A3)); send(0, 9'h0A3, 8, -1, 2'b11, 1);
    repeat (5) tick();
    check("basic_drained", exp_a.size(), 0);
    check("basic_valid_low", valid_a, 0);
    check("basic_hold_data", data_a, 8'hA3);

    // glitch shorter than half a bit
    drive(0, 1'b0, 3);
    saw = 1'b0;
    for (int i = 0; i < 20; i++) begin
      rx_a = 1'b1;
      tick();
      if (busy_a) saw = 1'b1;
    end
    check("glitch_busy_pulse", saw, 1);
    check("glitch_count", count_a, 0);
    check("glitch_busy_end", busy_a, 0);
    exp_a.push_back(ent(0, 0, 9'h07E)); send(0, 9'h07E, 8, -1, 2'b11, 1);

    // overflow with consumer stalled
    ready_a = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) exp_a.push_back(ent(0, 0, 9'(i)));
      send(0, 9'(i), 8, -1, 2'b11, 1);
    end
    check("ovf_count", count_a, 4);
    check("ovf_flag", overflow_a, 1);
    check("ovf_head", data_a, 8'h01);
    ready_a = 1'b1;
    repeat (10) tick();
    check("ovf_drain_count", count_a, 0);
    check("ovf_drain_queue", exp_a.size(), 0);
    check("ovf_sticky", overflow_a, 1);

    // 7E2: parity good / bad, bad second stop bit, break
    exp_b.push_back(ent(0, 0, 9'h041)); send(1, 9'h041, 7, 0, 2'b11, 2);
    exp_b.push_back(ent(1, 0, 9'h041)); send(1, 9'h041, 7, 1, 2'b11, 2);
    exp_b.push_back(ent(0, 1, 9'h012)); send(1, 9'h012, 7, 0, 2'b01, 2);
    exp_b.push_back(ent(0, 1, 9'h000));
    drive(1, 1'b0, 300);
    drive(1, 1'b1, 30);
    check("break_single_entry", exp_b.size(), 0);
    check("break_count", count_b, 0);
    check("break_idle", busy_b, 0);
    exp_b.push_back(ent(0, 0, 9'h041)); send(1, 9'h041, 7, 0, 2'b11, 2);
    repeat (5) tick();
    check("b_drained", exp_b.size(), 0);

    // reset in the middle of a character with two entries queued
    ready_a = 1'b0;
    exp_a.push_back(ent(0, 0, 9'h011)); send(0, 9'h011, 8, -1, 2'b11, 1);
    exp_a.push_back(ent(0, 0, 9'h022)); send(0, 9'h022, 8, -1, 2'b11, 1);
    check("pre_rst_count", count_a, 2);
    drive(0, 1'b0, 10);
    drive(0, 1'b1, 20);
    drive(0, 1'b0, 4);
    check("mid_char_busy", busy_a, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_outputs", {data_a, perr_a, ferr_a, valid_a, overflow_a, busy_a}, 0);
    check("mid_rst_count", count_a, 0);
    exp_a.delete();
    drive(0, 1'b0, 6);
    rst_n = 1'b1;
    drive(0, 1'b0, 8);
    drive(0, 1'b1, 30);
    check("post_rst_idle", {busy_a, valid_a}, 0);
    ready_a = 1'b1;
    exp_a.push_back(ent(0, 0, 9'h05A)); send(0, 9'h05A, 8, -1, 2'b11, 1);
    repeat (5) tick();
    check("post_rst_count", count_a, 0);
    check("post_rst_drained", exp_a.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
